// File: rtl/jtoutrun_sndrom_arb.sv
// Sound ROM arbiter: shares one SDRAM byte port between the sound Z80
// program fetch and the PCM sample fetch. Each requester has a one-byte
// cache so repeated reads of the same address are answered without SDRAM.
// PCM has fixed priority, but a saturating counter bounds how many PCM
// grants can pass a waiting Z80 request.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate between pending misses
//   ARM   | sd_cs just raised; sd_ok ignored (may be stale from last access)
//   WAIT  | waiting for sd_ok; on it, fill owner's cache and release sd_cs
module jtoutrun_sndrom_arb #(
    parameter logic [19:0] PCM_OFFSET = 20'h10000,
    parameter logic [1:0]  STARVE_MAX = 2'd3
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        z_cs,
    input  logic [15:0] z_addr,
    output logic [7:0]  z_data,
    output logic        z_ok,
    input  logic        p_cs,
    input  logic [18:0] p_addr,
    output logic [7:0]  p_data,
    output logic        p_ok,
    output logic [19:0] sd_addr,
    output logic        sd_cs,
    input  logic [7:0]  sd_data,
    input  logic        sd_ok
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT
    } state_t;

    state_t      state_q;
    logic        owner_pcm_q;
    logic [18:0] tag_q;
    logic [19:0] sd_addr_q;
    logic        sd_cs_q;
    logic [1:0]  starve_q;

    logic        z_valid_q;
    logic [15:0] z_tag_q;
    logic [7:0]  z_data_q;
    logic        z_ok_q;

    logic        p_valid_q;
    logic [18:0] p_tag_q;
    logic [7:0]  p_data_q;
    logic        p_ok_q;

    logic        z_hit;
    logic        p_hit;
    logic        z_miss;
    logic        p_miss;
    logic        grant_p;
    logic        grant_z;
    logic [1:0]  starve_inc;
    logic [19:0] p_sd_addr;
    logic        z_ok_d;
    logic        p_ok_d;

    // Cache lookup and arbitration decision for the IDLE state
    always_comb begin
        z_hit      = z_cs & z_valid_q & (z_tag_q == z_addr);
        p_hit      = p_cs & p_valid_q & (p_tag_q == p_addr);
        z_miss     = z_cs & ~z_hit;
        p_miss     = p_cs & ~p_hit;
        grant_p    = p_miss & (~z_miss | (starve_q < STARVE_MAX));
        grant_z    = z_miss & ~grant_p;
        starve_inc = (starve_q == STARVE_MAX) ? starve_q : starve_q + 2'd1;
        p_sd_addr  = PCM_OFFSET + {1'b0, p_addr};
        z_ok_d     = z_hit;
        p_ok_d     = p_hit;
    end

    // ok flags follow the hit condition one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_ok_q <= 1'b0;
            p_ok_q <= 1'b0;
        end else begin
            z_ok_q <= z_ok_d;
            p_ok_q <= p_ok_d;
        end
    end

    // Transaction FSM, starvation counter and cache fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_pcm_q <= 1'b0;
            tag_q       <= '0;
            sd_addr_q   <= '0;
            sd_cs_q     <= 1'b0;
            starve_q    <= '0;
            z_valid_q   <= 1'b0;
            z_tag_q     <= '0;
            z_data_q    <= '0;
            p_valid_q   <= 1'b0;
            p_tag_q     <= '0;
            p_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_p) begin
                        owner_pcm_q <= 1'b1;
                        tag_q       <= p_addr;
                        sd_addr_q   <= p_sd_addr;
                        sd_cs_q     <= 1'b1;
                        starve_q    <= z_miss ? starve_inc : 2'd0;
                        state_q     <= ST_ARM;
                    end else if (grant_z) begin
                        owner_pcm_q <= 1'b0;
                        tag_q       <= {3'd0, z_addr};
                        sd_addr_q   <= {4'd0, z_addr};
                        sd_cs_q     <= 1'b1;
                        starve_q    <= 2'd0;
                        state_q     <= ST_ARM;
                    end else begin
                        // no grant implies no Z80 miss
                        starve_q <= 2'd0;
                    end
                end
                ST_ARM: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sd_ok) begin
                        if (owner_pcm_q) begin
                            p_valid_q <= 1'b1;
                            p_tag_q   <= tag_q;
                            p_data_q  <= sd_data;
                        end else begin
                            z_valid_q <= 1'b1;
                            z_tag_q   <= tag_q[15:0];
                            z_data_q  <= sd_data;
                        end
                        sd_cs_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    sd_cs_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign z_data  = z_data_q;
    assign z_ok    = z_ok_q;
    assign p_data  = p_data_q;
    assign p_ok    = p_ok_q;
    assign sd_addr = sd_addr_q;
    assign sd_cs   = sd_cs_q;

endmodule
